// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB requester: FSM state encoding,
// default geometry and the watchdog counter sizing.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int unsigned DEF_ADDR_LIMIT     = 256;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;
    localparam int unsigned WD_WIDTH           = $clog2(DEF_TIMEOUT_CYCLES + 1);

    // Counter width able to hold 0..timeout inclusive.
    function automatic int unsigned wd_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_master_watchdog.sv
// ACCESS-phase watchdog: counts consecutive stalled cycles and flags the
// cycle on which the stall limit is reached.
module apb_watchdog
    import apb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned    W    = wd_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 1);
    localparam logic [W-1:0]   MAXC = W'(TIMEOUT_CYCLES);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != MAXC)) begin
            count <= count + 1'b1;
        end
    end

    // Fires during the stalled cycle that would be the limit-th one.
    assign expired = count_en && (count == LAST);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: accepts a command, runs SETUP/ACCESS
// with a stall watchdog, and holds the response until it is consumed.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned ADDR_LIMIT     = DEF_ADDR_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    input  logic        pready,
    input  logic [31:0] prdata
);

    state_t state;
    logic   in_range;
    logic   wd_clear;
    logic   wd_count_en;
    logic   wd_expired;

    always_comb begin
        req_ready   = (state == IDLE);
        in_range    = (req_addr < 32'(ADDR_LIMIT));
        wd_clear    = (state == SETUP);
        wd_count_en = (state == ACCESS) && !pready;
    end

    apb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wd_clear),
        .count_en (wd_count_en),
        .expired  (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (in_range) begin
                            pwrite  <= req_write;
                            paddr   <= req_addr;
                            pwdata  <= req_wdata;
                            psel    <= 1'b1;
                            penable <= 1'b0;
                            state   <= SETUP;
                        end else begin
                            // Out-of-range commands never reach the bus.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        state     <= RESP;
                    end else if (wd_expired) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small APB completer memory model.
module tb_apb_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic        pready;
    logic [31:0] prdata;

    logic [31:0] mem [0:255];

    int vec  = 0;
    int miss = 0;

    apb_master #(
        .TIMEOUT_CYCLES(16),
        .ADDR_LIMIT(256)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pready    (pready),
        .prdata    (prdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb prdata = mem[paddr[7:0]];

    always @(posedge clk) begin
        if (psel && penable && pready && pwrite)
            mem[paddr[7:0]] <= pwdata;
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vec++;
        if (psel !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b0) begin
            miss++;
            $display("FAIL reset_apb_ctrl: got psel=%b penable=%b pwrite=%b expected 0 0 0", psel, penable, pwrite);
        end
        vec++;
        if (paddr !== 32'h0 || pwdata !== 32'h0) begin
            miss++;
            $display("FAIL reset_apb_data: got paddr=%h pwdata=%h expected 0 0", paddr, pwdata);
        end
        vec++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            miss++;
            $display("FAIL reset_rsp: got v=%b e=%b d=%h expected 0 0 0", rsp_valid, rsp_err, rsp_rdata);
        end
        vec++;
        if (req_ready !== 1'b1) begin
            miss++;
            $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        int psel_cnt = 0;
        int pen_cnt  = 0;
        int first_v  = 0;
        vec++;
        if (req_ready !== 1'b1) begin
            miss++;
            $display("FAIL write_req_ready: got %b expected 1", req_ready);
        end
        issue(1'b1, 32'h10, 32'hDEADBEEF);
        vec++;
        if (paddr !== 32'h10 || pwdata !== 32'hDEADBEEF || pwrite !== 1'b1 || req_ready !== 1'b0) begin
            miss++;
            $display("FAIL write_setup_bus: got a=%h d=%h w=%b rr=%b expected 10 deadbeef 1 0", paddr, pwdata, pwrite, req_ready);
        end
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) begin
                @(posedge clk); #1;
            end
            if (psel) psel_cnt++;
            if (penable) pen_cnt++;
            if (rsp_valid && first_v == 0) first_v = i;
        end
        vec++;
        if (psel_cnt != 2 || pen_cnt != 1) begin
            miss++;
            $display("FAIL write_phases: got psel_cycles=%0d penable_cycles=%0d expected 2 1", psel_cnt, pen_cnt);
        end
        vec++;
        if (first_v != 3) begin
            miss++;
            $display("FAIL write_latency: got %0d expected 3", first_v);
        end
        vec++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            miss++;
            $display("FAIL write_rsp: got e=%b d=%h expected 0 0", rsp_err, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        vec++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miss++;
            $display("FAIL write_handshake: got v=%b rr=%b expected 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_read();
        issue(1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        vec++;
        if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 32'h10 || pwrite !== 1'b0) begin
            miss++;
            $display("FAIL read_access_bus: got sel=%b en=%b a=%h w=%b expected 1 1 10 0", psel, penable, paddr, pwrite);
        end
        @(posedge clk); #1;
        vec++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
            miss++;
            $display("FAIL read_rsp: got v=%b d=%h e=%b expected 1 deadbeef 0", rsp_valid, rsp_rdata, rsp_err);
        end
        vec++;
        if (psel !== 1'b0 || paddr !== 32'h10) begin
            miss++;
            $display("FAIL read_release: got sel=%b a=%h expected 0 10", psel, paddr);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_out_of_range();
        int sel_seen = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'd256;
        req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (psel) sel_seen++;
        vec++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            miss++;
            $display("FAIL oor_rsp: got v=%b e=%b d=%h expected 1 1 0", rsp_valid, rsp_err, rsp_rdata);
        end
        @(posedge clk); #1;
        if (psel) sel_seen++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (psel) sel_seen++;
        vec++;
        if (sel_seen != 0) begin
            miss++;
            $display("FAIL oor_psel: got %0d psel cycles expected 0", sel_seen);
        end
        // Highest in-range word goes to the bus.
        issue(1'b1, 32'd255, 32'hA5A5_0001);
        vec++;
        if (psel !== 1'b1 || paddr !== 32'd255) begin
            miss++;
            $display("FAIL edge_addr_setup: got sel=%b a=%h expected 1 ff", psel, paddr);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        vec++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
            miss++;
            $display("FAIL edge_addr_rsp: got v=%b e=%b expected 1 0", rsp_valid, rsp_err);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_stall(input logic late_ready, output int acc, output logic got_rsp);
        acc     = 0;
        got_rsp = 1'b0;
        pready  = 1'b0;
        issue(1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                got_rsp = 1'b1;
                break;
            end
            if (psel && penable) begin
                acc++;
                pready = late_ready && (acc == 16);
            end
        end
        pready = 1'b1;
    endtask

    task automatic test_timeout();
        int   acc;
        logic got;
        run_stall(1'b0, acc, got);
        vec++;
        if (!got || acc != 16) begin
            miss++;
            $display("FAIL timeout_cycles: got rsp=%b access_cycles=%0d expected 1 16", got, acc);
        end
        vec++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            miss++;
            $display("FAIL timeout_rsp: got e=%b d=%h expected 1 0", rsp_err, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        run_stall(1'b1, acc, got);
        vec++;
        if (!got || acc != 16) begin
            miss++;
            $display("FAIL late_ready_cycles: got rsp=%b access_cycles=%0d expected 1 16", got, acc);
        end
        vec++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
            miss++;
            $display("FAIL late_ready_rsp: got e=%b d=%h expected 0 deadbeef", rsp_err, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Offer the next command while the response is still pending.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            vec++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0 || psel !== 1'b0) begin
                miss++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h rr=%b sel=%b expected 1 deadbeef 0 0", i, rsp_valid, rsp_rdata, req_ready, psel);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        vec++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || psel !== 1'b0) begin
            miss++;
            $display("FAIL bp_idle_gap: got v=%b rr=%b sel=%b expected 0 1 0", rsp_valid, req_ready, psel);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        vec++;
        if (psel !== 1'b1 || paddr !== 32'h40 || pwrite !== 1'b1) begin
            miss++;
            $display("FAIL bp_next_accept: got sel=%b a=%h w=%b expected 1 40 1", psel, paddr, pwrite);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_in_access();
        int v_seen = 0;
        pready = 1'b0;
        issue(1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        vec++;
        if (psel !== 1'b1 || penable !== 1'b1) begin
            miss++;
            $display("FAIL rst_pre_access: got sel=%b en=%b expected 1 1", psel, penable);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vec++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
            miss++;
            $display("FAIL rst_async_drop: got sel=%b en=%b expected 0 0", psel, penable);
        end
        @(posedge clk); #1;
        rst_n  = 1'b1;
        pready = 1'b1;
        vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== 1'b0) begin
            miss++;
            $display("FAIL rst_release: got rr=%b v=%b sel=%b expected 1 0 0", req_ready, rsp_valid, psel);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (rsp_valid || psel) v_seen++;
        end
        vec++;
        if (v_seen != 0 || req_ready !== 1'b1) begin
            miss++;
            $display("FAIL rst_no_response: got active_cycles=%0d rr=%b expected 0 1", v_seen, req_ready);
        end
    endtask

    initial begin
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        pready    = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_out_of_range();
        test_timeout();
        test_back_to_back();
        test_reset_in_access();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: consecutive ACCESS cycles with pready low before the transfer aborts.
REQ-002 SHALL have parameter ADDR_LIMIT, default 256: number of addressable words; req_addr >= ADDR_LIMIT is out of range.
REQ-003 SHALL have one clock and an asynchronous active-low reset, ports listed first: clk  in  1  rising-edge clock; rst_n  in  1  reset, active low.
REQ-004 SHALL have: req_valid  in  1  command offered.
REQ-005 SHALL have: req_ready  out  1  command accepted when high together with req_valid.
REQ-006 SHALL have: req_write  in  1  1 = write, 0 = read.
REQ-007 SHALL have: req_addr  in  32  word address.
REQ-008 SHALL have: req_wdata  in  32  write data.
REQ-009 SHALL have: rsp_valid  out  1  response available.
REQ-010 SHALL have: rsp_ready  in  1  response consumed.
REQ-011 SHALL have: rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-012 SHALL have: rsp_err  out  1  out-of-range address or timeout.
REQ-013 SHALL have: paddr, pwdata  out  32 each; psel, penable, pwrite  out  1 each; pready  in  1; prdata  in  32. These form the APB requester port.

Function
REQ-014 SHALL implement states IDLE, SETUP, ACCESS and RESP.
REQ-015 In IDLE, req_ready SHALL be 1; in every other state, 0. req_ready is combinational from state.
REQ-016 IDLE with req_valid=1 and req_addr < ADDR_LIMIT: at that edge, SHALL latch write/addr/wdata onto pwrite/paddr/pwdata and go to SETUP.
REQ-017 IDLE with req_valid=1 and req_addr >= ADDR_LIMIT: SHALL go directly to RESP with rsp_err=1 and rsp_rdata=0; psel SHALL never assert.
REQ-018 SETUP SHALL drive psel=1, penable=0 for exactly one cycle, then go to ACCESS.
REQ-019 ACCESS SHALL drive psel=1, penable=1. paddr, pwrite and pwdata SHALL stay stable from SETUP until ACCESS exits.
REQ-020 In ACCESS, pready sampled 1 SHALL complete the transfer: for reads, rsp_rdata=prdata; for writes, rsp_rdata=0; rsp_err=0; next state RESP.
REQ-021 A watchdog count SHALL clear on SETUP entry and increment on each ACCESS cycle with pready=0.
REQ-022 On the TIMEOUT_CYCLES-th consecutive low-pready cycle, ACCESS SHALL exit to RESP with rsp_err=1 and rsp_rdata=0.
REQ-023 If pready=1 on the same edge the timeout would fire, completion SHALL win.
REQ-024 On ACCESS exit, psel and penable SHALL deassert the following cycle. paddr, pwdata and pwrite SHALL hold their last values.
REQ-025 Minimum latency: accept edge -> SETUP -> ACCESS (pready=1) -> rsp_valid high on the 3rd cycle after acceptance.
REQ-026 RESP SHALL hold rsp_valid=1 with rsp_rdata and rsp_err stable until rsp_ready=1, then return to IDLE. No back-to-back accept in the same cycle.
REQ-027 Back-to-back commands SHALL therefore have at least one IDLE cycle between transfers, with psel low for at least 1 cycle.
REQ-028 All APB and rsp_* outputs SHALL be registered.

Reset
REQ-029 rst_n low SHALL asynchronously force: state IDLE; psel, penable, pwrite 0; paddr, pwdata 0; rsp_valid, rsp_err 0; rsp_rdata 0; watchdog 0.
REQ-030 Reset asserted mid-transfer (SETUP, ACCESS or RESP) SHALL abandon the transfer with no response issued. psel SHALL drop immediately.
REQ-031 After rst_n deasserts, the first command SHALL be acceptable on the first rising edge.

Structure
REQ-032 Package apb_master_pkg SHALL hold the state enum typedef, the default ADDR_LIMIT and TIMEOUT_CYCLES values, and the watchdog counter width ($clog2(TIMEOUT_CYCLES+1)).
REQ-033 The watchdog SHALL be a sub-module apb_watchdog with inputs clear, count_en and expired output. All other logic SHALL remain in apb_master.

Verification
REQ-034 Write: addr=0x10, wdata=0xDEADBEEF, pready tied 1 -> psel high 2 cycles, penable high 1 cycle, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-035 Read-back: addr=0x10 after the write, slave model returns 0xDEADBEEF -> rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-036 Out of range: addr=256 -> rsp_valid with rsp_err=1 and rsp_rdata=0; psel never asserted.
REQ-037 Timeout: pready held 0 -> abort after exactly 16 ACCESS cycles with rsp_err=1; pready=1 on cycle 16 -> normal completion.
REQ-038 Backpressure: rsp_ready low for 5 cycles -> rsp_valid/rsp_rdata stable and req_ready=0 throughout; the next command is accepted only after the handshake.
REQ-039 Reset in ACCESS: rst_n low for 1 cycle -> psel=0 immediately, no rsp_valid, IDLE and req_ready=1 after release.
